// File: rtl/ysyx_rnu_pkg.sv
// Shared types and constants for the rename/allocate stage.
// Architectural register width and ROB depth come from YSYX_REG_LEN and
// YSYX_ROB_SIZE; local defaults apply when the build does not supply them.
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 4
`endif

package ysyx_rnu_pkg;
  localparam int RLEN     = `YSYX_REG_LEN;
  localparam int ROB_SIZE = `YSYX_ROB_SIZE;
  localparam int PTRW     = $clog2(ROB_SIZE);
  localparam int TAGW     = PTRW + 1;
  localparam int CNTW     = PTRW + 1;

  typedef logic [TAGW-1:0] tag_t;
  typedef logic [PTRW-1:0] ptr_t;
  typedef logic [CNTW-1:0] cnt_t;
  typedef logic [RLEN-1:0] reg_t;

  // Tag 0 means the source value already sits in the register file.
  localparam tag_t TAG_NONE = '0;

  // ROB slot n is published to the rest of the machine as tag n+1.
  function automatic tag_t ptr2tag(input ptr_t p);
    return {1'b0, p} + tag_t'(1);
  endfunction
endpackage

// File: rtl/ysyx_rnu_alloc_if.sv
// Handshake bundle between IDU/ROB (master) and the allocator (slave):
// the decoded-instruction input, the renamed output and the commit port.
interface ysyx_rnu_alloc_if;
  import ysyx_rnu_pkg::*;

  logic in_valid;
  logic in_ready;
  logic in_wen;
  reg_t in_rd;
  reg_t in_rs1;
  reg_t in_rs2;

  logic out_valid;
  logic out_ready;
  tag_t out_qj;
  tag_t out_qk;
  tag_t out_dest;

  logic cm_valid;
  tag_t cm_dest;
  reg_t cm_rd;

  logic rob_full;

  modport master (
    output in_valid, in_wen, in_rd, in_rs1, in_rs2, out_ready,
           cm_valid, cm_dest, cm_rd,
    input  in_ready, out_valid, out_qj, out_qk, out_dest, rob_full
  );

  modport slave (
    input  in_valid, in_wen, in_rd, in_rs1, in_rs2, out_ready,
           cm_valid, cm_dest, cm_rd,
    output in_ready, out_valid, out_qj, out_qk, out_dest, rob_full
  );
endinterface

// File: rtl/ysyx_rnu_rat.sv
// Register alias table: architectural register -> ROB tag of the youngest
// in-flight writer. Two lookup ports see a same-cycle commit as already
// retired. Register 0 never leaves TAG_NONE.
module ysyx_rnu_rat
  import ysyx_rnu_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  reg_t rs1,
  input  reg_t rs2,
  output tag_t qj,
  output tag_t qk,
  input  logic cm_fire,
  input  tag_t cm_dest,
  input  reg_t cm_rd,
  input  logic wr_en,
  input  reg_t wr_rd,
  input  tag_t wr_tag
);
  localparam int NREG = 1 << RLEN;

  tag_t map [NREG];
  tag_t raw1;
  tag_t raw2;

  // Lookup with x0 forced ready and bypass of the tag retiring this cycle.
  always_comb begin
    raw1 = map[rs1];
    raw2 = map[rs2];
    qj   = raw1;
    qk   = raw2;
    if (rs1 == '0 || (cm_fire && raw1 == cm_dest)) qj = TAG_NONE;
    if (rs2 == '0 || (cm_fire && raw2 == cm_dest)) qk = TAG_NONE;
  end

  // Dispatch write beats the commit clear; the clear only hits if no younger writer remapped rd.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) map[i] <= TAG_NONE;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) map[i] <= TAG_NONE;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en && wr_rd == reg_t'(i))
          map[i] <= wr_tag;
        else if (cm_fire && cm_rd == reg_t'(i) && map[i] == cm_dest)
          map[i] <= TAG_NONE;
      end
    end
  end
endmodule

// File: rtl/ysyx_rnu_alloc.sv
// Rename/allocate stage between IDU and RS/ROB dispatch. Hands out ROB tags
// in order, looks up source producers in the RAT and presents the renamed
// bundle one cycle after acceptance. Optional stall counters are built when
// YSYX_RNU_PERF_EN is defined.
module ysyx_rnu_alloc
  import ysyx_rnu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  ysyx_rnu_alloc_if.slave  bus
`ifdef YSYX_RNU_PERF_EN
  ,
  output logic [31:0]      perf_full_stall,
  output logic [31:0]      perf_bp_stall
`endif
);
  ptr_t head;
  ptr_t tail;
  cnt_t count;
  cnt_t count_next;
  logic rob_full_q;
  logic out_valid_q;
  tag_t out_qj_q;
  tag_t out_qk_q;
  tag_t out_dest_q;
  tag_t look_qj;
  tag_t look_qk;
  logic accept;
  logic cm_fire;
  logic rat_wen;

  // A commit on an empty ROB or in a flush cycle is dropped.
  assign cm_fire      = bus.cm_valid & (count != '0) & !flush;
  assign bus.in_ready = !flush & !rob_full_q & (!out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign rat_wen      = accept & bus.in_wen & (bus.in_rd != '0);

  assign bus.out_valid = out_valid_q;
  assign bus.out_qj    = out_qj_q;
  assign bus.out_qk    = out_qk_q;
  assign bus.out_dest  = out_dest_q;
  assign bus.rob_full  = rob_full_q;

  ysyx_rnu_rat u_rat (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .qj      (look_qj),
    .qk      (look_qk),
    .cm_fire (cm_fire),
    .cm_dest (bus.cm_dest),
    .cm_rd   (bus.cm_rd),
    .wr_en   (rat_wen),
    .wr_rd   (bus.in_rd),
    .wr_tag  (ptr2tag(tail))
  );

  // Occupancy moves only when exactly one of allocate/commit happens.
  always_comb begin
    count_next = count;
    case ({accept, cm_fire})
      2'b10:   count_next = count + cnt_t'(1);
      2'b01:   count_next = count - cnt_t'(1);
      default: count_next = count;
    endcase
  end

  // ROB pointers, occupancy and the registered full flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rob_full_q <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rob_full_q <= 1'b0;
    end else begin
      if (accept)  tail <= tail + ptr_t'(1);
      if (cm_fire) head <= head + ptr_t'(1);
      count      <= count_next;
      rob_full_q <= (count_next == cnt_t'(ROB_SIZE));
    end
  end

  // Output register: load on accept, hold until taken, drop after handoff.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_qj_q    <= TAG_NONE;
      out_qk_q    <= TAG_NONE;
      out_dest_q  <= TAG_NONE;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_qj_q    <= look_qj;
      out_qk_q    <= look_qk;
      out_dest_q  <= ptr2tag(tail);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  a_no_commit_when_empty: assert property (
    @(posedge clock) disable iff (!reset)
    (bus.cm_valid && !flush) |-> (count != '0));

  a_commit_is_head: assert property (
    @(posedge clock) disable iff (!reset)
    (bus.cm_valid && !flush && count != '0) |-> (bus.cm_dest == ptr2tag(head)));

`ifdef YSYX_RNU_PERF_EN
  // Saturating stall counters; flush leaves them untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_full_stall <= '0;
      perf_bp_stall   <= '0;
    end else begin
      if (bus.in_valid && rob_full_q && perf_full_stall != 32'hFFFF_FFFF)
        perf_full_stall <= perf_full_stall + 32'd1;
      if (out_valid_q && !bus.out_ready && perf_bp_stall != 32'hFFFF_FFFF)
        perf_bp_stall <= perf_bp_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_rnu_alloc.sv
// Scoreboard bench for ysyx_rnu_alloc (ROB_SIZE of 4 assumed by the
// hand-computed tags). Stall counters are checked when YSYX_RNU_PERF_EN
// is defined.
module tb_ysyx_rnu_alloc;
  import ysyx_rnu_pkg::*;

  typedef struct packed {
    tag_t qj;
    tag_t qk;
    tag_t dest;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  ysyx_rnu_alloc_if bus();

`ifdef YSYX_RNU_PERF_EN
  logic [31:0] perf_full_stall;
  logic [31:0] perf_bp_stall;
`endif

  ysyx_rnu_alloc dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .bus             (bus)
`ifdef YSYX_RNU_PERF_EN
    ,
    .perf_full_stall (perf_full_stall),
    .perf_bp_stall   (perf_bp_stall)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One instruction (optionally with a same-cycle commit); expected bundle goes to the scoreboard.
  task automatic apply_stimulus(input logic wen, input int rd, input int rs1, input int rs2,
                                input logic cmv, input int cmd, input int cmr,
                                input int eqj, input int eqk, input int edest);
    exp_t e;
    e.qj = tag_t'(eqj);
    e.qk = tag_t'(eqk);
    e.dest = tag_t'(edest);
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_wen   = wen;
    bus.in_rd    = reg_t'(rd);
    bus.in_rs1   = reg_t'(rs1);
    bus.in_rs2   = reg_t'(rs2);
    bus.cm_valid = cmv;
    bus.cm_dest  = tag_t'(cmd);
    bus.cm_rd    = reg_t'(cmr);
    @(negedge clock);
    check_output("in_ready_on_issue", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.cm_valid = 1'b0;
  endtask

  task automatic commit(input int cmd, input int cmr);
    bus.cm_valid = 1'b1;
    bus.cm_dest  = tag_t'(cmd);
    bus.cm_rd    = reg_t'(cmr);
    @(posedge clock);
    #1;
    bus.cm_valid = 1'b0;
  endtask

  // Monitor: every bundle handed downstream must match the oldest expectation.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL bundle_unexpected: got qj=%0d qk=%0d dest=%0d, expected none",
                 bus.out_qj, bus.out_qk, bus.out_dest);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.out_qj !== e.qj || bus.out_qk !== e.qk || bus.out_dest !== e.dest) begin
          errors++;
          $display("[TB] FAIL bundle: got qj=%0d qk=%0d dest=%0d, expected qj=%0d qk=%0d dest=%0d",
                   bus.out_qj, bus.out_qk, bus.out_dest, e.qj, e.qk, e.dest);
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_wen    = 1'b0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.out_ready = 1'b1;
    bus.cm_valid  = 1'b0;
    bus.cm_dest   = '0;
    bus.cm_rd     = '0;

    #3;
    check_output("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check_output("reset_rob_full",  {31'd0, bus.rob_full},  32'd0);
    check_output("reset_out_dest",  32'(bus.out_dest), 32'd0);
    check_output("reset_out_qj",    32'(bus.out_qj),   32'd0);
    #9 reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic allocation, rename chain and a stale commit that must not clear RAT[5].
    apply_stimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(1, 5, 5, 0, 0, 0, 0, 1, 0, 2);
    commit(1, 5);
    apply_stimulus(0, 0, 5, 5, 0, 0, 0, 2, 2, 3);
    apply_stimulus(1, 3, 0, 5, 0, 0, 0, 0, 2, 4);
    apply_stimulus(1, 7, 3, 7, 0, 0, 0, 4, 0, 1);

    // ROB full: in_ready stays low even with a pending instruction.
    bus.in_valid = 1'b1;
    bus.in_wen = 1'b0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    repeat (2) begin
      @(negedge clock);
      check_output("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_output("full_rob_full", {31'd0, bus.rob_full}, 32'd1);
    end
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;

    // Drain one, then commit+accept together keeps occupancy; tail wraps.
    commit(2, 5);
    apply_stimulus(1, 5, 5, 7, 1, 3, 0, 0, 1, 2);
    apply_stimulus(0, 0, 3, 5, 0, 0, 0, 4, 2, 3);
    @(negedge clock);
    check_output("refull_rob_full", {31'd0, bus.rob_full}, 32'd1);
    @(posedge clock);
    #1;
    commit(4, 3);

    // Commit bypass on lookup, then confirm the clear landed.
    apply_stimulus(1, 3, 7, 5, 1, 1, 7, 0, 2, 4);
    apply_stimulus(0, 0, 7, 3, 0, 0, 0, 0, 4, 1);
    commit(2, 5);
    commit(3, 0);

    // Dispatch write to rd wins over the same-cycle commit clear of rd.
    apply_stimulus(1, 3, 3, 5, 1, 4, 3, 0, 0, 2);
    apply_stimulus(0, 0, 3, 0, 0, 0, 0, 2, 0, 3);
    commit(1, 0);
    apply_stimulus(0, 0, 3, 3, 1, 2, 3, 0, 0, 4);
    apply_stimulus(0, 0, 3, 5, 0, 0, 0, 0, 0, 1);
    commit(3, 0);

    // Backpressure: the held bundle stays stable and blocks input.
    apply_stimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 2);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_wen    = 1'b1;
    bus.in_rd     = reg_t'(4);
    bus.in_rs1    = reg_t'(9);
    bus.in_rs2    = reg_t'(9);
    repeat (4) begin
      @(negedge clock);
      check_output("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check_output("hold_out_dest",  32'(bus.out_dest), 32'd2);
      check_output("hold_out_qj",    32'(bus.out_qj),   32'd0);
      check_output("hold_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    end

    // Flush with pending accept and commit: everything is discarded.
    #1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    bus.cm_valid = 1'b1;
    bus.cm_dest = tag_t'(4);
    bus.cm_rd = '0;
    #1;
    check_output("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    bus.cm_valid = 1'b0;
    bus.in_valid = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clock);
    check_output("post_flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("post_flush_rob_full",  {31'd0, bus.rob_full},  32'd0);
    @(posedge clock);
    #1;
    apply_stimulus(1, 5, 5, 3, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 5, 9, 0, 0, 0, 1, 0, 2);
    @(negedge clock);
    @(negedge clock);
    check_output("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Fresh start: fill, then stall on full and on backpressure.
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 1; i <= 4; i++) apply_stimulus(1, i, 0, 0, 0, 0, 0, 0, 0, i);
    bus.in_valid = 1'b1;
    bus.in_wen = 1'b0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check_output("burst_rob_full", {31'd0, bus.rob_full}, 32'd1);
`ifdef YSYX_RNU_PERF_EN
    check_output("perf_full_stall", perf_full_stall, 32'd3);
    check_output("perf_bp_stall",   perf_bp_stall,   32'd2);
`endif
    @(posedge clock);
    #1;
    commit(1, 1);
    apply_stimulus(1, 5, 1, 2, 0, 0, 0, 0, 2, 1);
    check_output("burst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check_output("burst_out_qk",    32'(bus.out_qk),   32'd2);

    // Asynchronous reset mid-burst, observed before the next clock edge.
    bus.in_valid = 1'b1;
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_output("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("async_out_dest",  32'(bus.out_dest), 32'd0);
    check_output("async_rob_full",  {31'd0, bus.rob_full}, 32'd0);
    check_output("async_in_ready",  {31'd0, bus.in_ready}, 32'd1);
`ifdef YSYX_RNU_PERF_EN
    check_output("async_perf_full", perf_full_stall, 32'd0);
    check_output("async_perf_bp",   perf_bp_stall,   32'd0);
`endif
    bus.in_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
